// File: rtl/mem_port_arbiter_if.sv
// Bundles the arbiter's two client channels, the memory-port channels and the
// sticky error flag.
//   slave  : the arbiter's view (takes client requests, drives the memory port)
//   master : the environment's view (clients plus memory model)
// Request packets are {addr, data, wr}: wr at bit 0, data above it, addr on top.
interface mem_port_arbiter_if #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 8
);
  localparam int unsigned PktW = Width + AddrWidth + 1;

  logic [PktW-1:0]  c0_req,        c1_req;
  logic             c0_req_valid,  c1_req_valid;
  logic             c0_req_bp,     c1_req_bp;
  logic [Width-1:0] c0_resp,       c1_resp;
  logic             c0_resp_valid, c1_resp_valid;
  logic             c0_resp_bp,    c1_resp_bp;
  logic [PktW-1:0]  mem_req;
  logic             mem_req_valid;
  logic             mem_req_bp;
  logic [Width-1:0] mem_resp;
  logic             mem_resp_valid;
  logic             mem_resp_bp;
  logic             err;

  modport slave (
    input  c0_req, c1_req, c0_req_valid, c1_req_valid, c0_resp_bp, c1_resp_bp,
           mem_req_bp, mem_resp, mem_resp_valid,
    output c0_req_bp, c1_req_bp, c0_resp, c1_resp, c0_resp_valid, c1_resp_valid,
           mem_req, mem_req_valid, mem_resp_bp, err
  );

  modport master (
    output c0_req, c1_req, c0_req_valid, c1_req_valid, c0_resp_bp, c1_resp_bp,
           mem_req_bp, mem_resp, mem_resp_valid,
    input  c0_req_bp, c1_req_bp, c0_resp, c1_resp, c0_resp_valid, c1_resp_valid,
           mem_req, mem_req_valid, mem_resp_bp, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter in front of a single memory port.
// A one-entry request register feeds the memory port; an owner FIFO
// (one bit per outstanding request) steers each in-order response back to
// the client that issued it. The response path is purely combinational.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : client request/response channels, memory port, sticky err flag
module mem_port_arbiter #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned TagDepth  = 4
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned PktW = Width + AddrWidth + 1;
  localparam int unsigned PtrW = $clog2(TagDepth);
  localparam logic [PtrW:0] CntFull = TagDepth[PtrW:0];

  logic                rq_full_q, rq_full_d;
  logic [PktW-1:0]     rq_data_q;
  logic                last_grant_q;
  logic [TagDepth-1:0] owner_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q, count_d;
  logic                err_q, err_d;

  logic head, fifo_empty, resp_bp, pop, can_load, can_grant, winner, grant;

  always_comb begin
    head       = owner_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    resp_bp    = head ? bus.c1_resp_bp : bus.c0_resp_bp;
    pop        = bus.mem_resp_valid & ~fifo_empty & ~resp_bp;
    can_load   = ~rq_full_q | ~bus.mem_req_bp;
    // A response retiring this cycle frees its tag, so a full FIFO can still
    // accept a new request in the same cycle.
    can_grant  = can_load & ((count_q != CntFull) | pop);
    winner     = (bus.c0_req_valid & bus.c1_req_valid) ? ~last_grant_q : bus.c1_req_valid;
    grant      = can_grant & (winner ? bus.c1_req_valid : bus.c0_req_valid);

    rq_full_d = rq_full_q;
    if (grant) begin
      rq_full_d = 1'b1;
    end else if (rq_full_q & ~bus.mem_req_bp) begin
      rq_full_d = 1'b0;
    end
    count_d = count_q + {{PtrW{1'b0}}, grant} - {{PtrW{1'b0}}, pop};
    err_d   = err_q | (bus.mem_resp_valid & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_full_q    <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rq_full_q <= rq_full_d;
      count_q   <= count_d;
      err_q     <= err_d;
      if (grant) begin
        last_grant_q <= winner;
        wr_ptr_q     <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Payload and tag storage carry no reset; their valid bits do.
  always_ff @(posedge clk) begin
    if (grant) begin
      rq_data_q         <= winner ? bus.c1_req : bus.c0_req;
      owner_q[wr_ptr_q] <= winner;
    end
  end

  assign bus.c0_req_bp     = ~(can_grant & ~winner);
  assign bus.c1_req_bp     = ~(can_grant & winner);
  assign bus.mem_req_valid = rq_full_q;
  assign bus.mem_req       = rq_data_q;
  assign bus.c0_resp       = bus.mem_resp;
  assign bus.c1_resp       = bus.mem_resp;
  assign bus.c0_resp_valid = bus.mem_resp_valid & ~fifo_empty & ~head;
  assign bus.c1_resp_valid = bus.mem_resp_valid & ~fifo_empty & head;
  assign bus.mem_resp_bp   = ~fifo_empty & resp_bp;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned Width     = 8;
  localparam int unsigned AddrWidth = 8;
  localparam int unsigned TagDepth  = 4;
  localparam int unsigned PktW      = Width + AddrWidth + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.Width(Width), .AddrWidth(AddrWidth)) bus ();

  mem_port_arbiter #(
    .Width    (Width),
    .AddrWidth(AddrWidth),
    .TagDepth (TagDepth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the request register is one slot holding a packet,
  // outstanding owners form a queue, responses go to the oldest owner.
  bit             m_full = 1'b0;
  bit [PktW-1:0]  m_data;
  bit             m_last = 1'b1;
  bit             m_err  = 1'b0;
  bit             m_q[$];
  bit             grant_log[$];

  always @(negedge clk) begin
    bit head, have, e_rbp, pop, room, slot, win, e_g0, e_g1, grant;
    if (reset) begin
      chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
      chk("rst_c0_resp_valid", 32'(bus.c0_resp_valid), 0);
      chk("rst_c1_resp_valid", 32'(bus.c1_resp_valid), 0);
      chk("rst_err", 32'(bus.err), 0);
      m_full = 1'b0; m_last = 1'b1; m_err = 1'b0; m_q.delete();
    end else begin
      have  = (m_q.size() > 0);
      head  = have ? m_q[0] : 1'b0;
      e_rbp = have && (head ? bus.c1_resp_bp : bus.c0_resp_bp);
      pop   = have && bus.mem_resp_valid && !e_rbp;
      room  = !m_full || !bus.mem_req_bp;
      slot  = (m_q.size() < TagDepth) || pop;
      if (bus.c0_req_valid && bus.c1_req_valid) win = !m_last;
      else win = bus.c1_req_valid;
      e_g0  = room && slot && !win;
      e_g1  = room && slot && win;
      grant = (e_g0 && bus.c0_req_valid) || (e_g1 && bus.c1_req_valid);

      chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_full));
      if (m_full) chk("mem_req", 32'(bus.mem_req), 32'(m_data));
      chk("c0_req_bp", 32'(bus.c0_req_bp), 32'(!e_g0));
      chk("c1_req_bp", 32'(bus.c1_req_bp), 32'(!e_g1));
      chk("c0_resp_valid", 32'(bus.c0_resp_valid), 32'(have && !head && bus.mem_resp_valid));
      chk("c1_resp_valid", 32'(bus.c1_resp_valid), 32'(have && head && bus.mem_resp_valid));
      if (bus.c0_resp_valid) chk("c0_resp", 32'(bus.c0_resp), 32'(bus.mem_resp));
      if (bus.c1_resp_valid) chk("c1_resp", 32'(bus.c1_resp), 32'(bus.mem_resp));
      chk("mem_resp_bp", 32'(bus.mem_resp_bp), 32'(e_rbp));
      chk("err", 32'(bus.err), 32'(m_err));

      if (bus.mem_resp_valid && !have) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (grant) begin
        m_q.push_back(win);
        grant_log.push_back(win);
        m_data = win ? bus.c1_req : bus.c0_req;
        m_full = 1'b1;
        m_last = win;
      end else if (m_full && !bus.mem_req_bp) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c0_req_valid = 0; bus.c1_req_valid = 0;
    bus.c0_resp_bp = 0; bus.c1_resp_bp = 0;
    bus.mem_req_bp = 0; bus.mem_resp_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  logic [PktW-1:0] pa, pb;
  bit acc0, acc1;
  int resp_pct;

  initial begin
    bus.c0_req = '0; bus.c1_req = '0; bus.mem_resp = '0;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;

    // Single client: {addr=05, data=A5, wr=1}
    bus.c0_req = 17'h0B4B; bus.c0_req_valid = 1;
    tick();
    bus.c0_req_valid = 0;
    #1;
    chk("single_valid", 32'(bus.mem_req_valid), 1);
    chk("single_req", 32'(bus.mem_req), 32'h0B4B);
    bus.mem_resp = 8'h5A; bus.mem_resp_valid = 1;
    #1;
    chk("single_c0_rv", 32'(bus.c0_resp_valid), 1);
    chk("single_c1_rv", 32'(bus.c1_resp_valid), 0);
    chk("single_c0_resp", 32'(bus.c0_resp), 32'h5A);
    tick();
    bus.mem_resp_valid = 0;

    // Contention: alternating grants starting with c0
    do_reset();
    grant_log.delete();
    pa = 17'h0AAA; pb = 17'h1555;
    bus.c0_req = pa; bus.c1_req = pb;
    bus.c0_req_valid = 1; bus.c1_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("cont_req", 32'(bus.mem_req), (i % 2 == 0) ? 32'(pa) : 32'(pb));
    end
    chk("cont_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("cont_order", 32'(grant_log[i]), 32'(i % 2));

    // FIFO full stall, then a response lets a grant through that same cycle
    #1;
    chk("full_c0_bp", 32'(bus.c0_req_bp), 1);
    chk("full_c1_bp", 32'(bus.c1_req_bp), 1);
    bus.mem_resp = 8'h33; bus.mem_resp_valid = 1;
    #1;
    chk("full_resume_c0_bp", 32'(bus.c0_req_bp), 0);
    chk("full_resume_c1_bp", 32'(bus.c1_req_bp), 1);
    tick();
    idle_inputs();

    // Memory-port backpressure with a full request register
    do_reset();
    bus.c0_req = 17'h0123; bus.c0_req_valid = 1;
    tick();
    bus.c0_req = 17'h0456; bus.mem_req_bp = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_stable", 32'(bus.mem_req), 32'h0123);
      chk("bp_c0_bp", 32'(bus.c0_req_bp), 1);
      chk("bp_c1_bp", 32'(bus.c1_req_bp), 1);
      tick();
    end
    bus.mem_req_bp = 0;
    #1;
    chk("bp_release_c0_bp", 32'(bus.c0_req_bp), 0);
    tick();
    bus.c0_req_valid = 0;
    #1;
    chk("bp_next_req", 32'(bus.mem_req), 32'h0456);
    chk("bp_next_valid", 32'(bus.mem_req_valid), 1);
    tick();
    #1;
    chk("bp_drained", 32'(bus.mem_req_valid), 0);

    // Response ordering: c1 read 0x10, then c0 read 0x20
    do_reset();
    bus.c1_req = 17'h2000; bus.c1_req_valid = 1;
    tick();
    bus.c1_req_valid = 0;
    bus.c0_req = 17'h4000; bus.c0_req_valid = 1;
    tick();
    bus.c0_req_valid = 0;
    bus.mem_resp = 8'h11; bus.mem_resp_valid = 1;
    #1;
    chk("ord_c1_rv", 32'(bus.c1_resp_valid), 1);
    chk("ord_c0_rv", 32'(bus.c0_resp_valid), 0);
    chk("ord_c1_resp", 32'(bus.c1_resp), 32'h11);
    tick();
    bus.mem_resp = 8'h22; bus.c0_resp_bp = 1;
    #1;
    chk("ord_stall_bp", 32'(bus.mem_resp_bp), 1);
    chk("ord_c0_rv2", 32'(bus.c0_resp_valid), 1);
    tick();
    #1;
    chk("ord_still_stall", 32'(bus.mem_resp_bp), 1);
    bus.c0_resp_bp = 0;
    #1;
    chk("ord_release_bp", 32'(bus.mem_resp_bp), 0);
    chk("ord_c0_resp", 32'(bus.c0_resp), 32'h22);
    tick();
    idle_inputs();

    // Response with nothing outstanding
    do_reset();
    bus.mem_resp_valid = 1;
    #1;
    chk("err_resp_bp", 32'(bus.mem_resp_bp), 0);
    chk("err_no_rv0", 32'(bus.c0_resp_valid), 0);
    chk("err_no_rv1", 32'(bus.c1_resp_valid), 0);
    tick();
    bus.mem_resp_valid = 0;
    #1;
    chk("err_set", 32'(bus.err), 1);
    tick();
    chk("err_sticky", 32'(bus.err), 1);

    // Reset mid-burst
    bus.c0_req_valid = 1; bus.c1_req_valid = 1;
    tick(); tick();
    chk("burst_valid", 32'(bus.mem_req_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req_valid", 32'(bus.mem_req_valid), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    chk("mid_rst_rv0", 32'(bus.c0_resp_valid), 0);
    chk("mid_rst_rv1", 32'(bus.c1_resp_valid), 0);
    tick();
    reset = 1'b0;
    idle_inputs();

    // Randomized traffic; clients hold their request until accepted
    acc0 = 1; acc1 = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resp_pct = ((cyc / 500) % 2 == 1) ? 20 : 70;
      if (!bus.c0_req_valid || acc0) begin
        bus.c0_req_valid = $urandom_range(0, 1) == 1;
        bus.c0_req = PktW'($urandom);
      end
      if (!bus.c1_req_valid || acc1) begin
        bus.c1_req_valid = $urandom_range(0, 1) == 1;
        bus.c1_req = PktW'($urandom);
      end
      bus.mem_req_bp = $urandom_range(0, 99) < 30;
      bus.c0_resp_bp = $urandom_range(0, 3) == 0;
      bus.c1_resp_bp = $urandom_range(0, 3) == 0;
      bus.mem_resp_valid = (m_q.size() > 0) && ($urandom_range(0, 99) < resp_pct);
      bus.mem_resp = Width'($urandom);
      #1;
      acc0 = bus.c0_req_valid && !bus.c0_req_bp;
      acc1 = bus.c1_req_valid && !bus.c1_req_bp;
      tick();
    end

    idle_inputs();
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
